// File: rtl/reg_file_pkg.sv
// Shared defaults and clear-sequencer state type
// for the multi-port register file.
package reg_file_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_NUM_RD = 2;

  typedef enum logic [0:0] {
    CLR_IDLE  = 1'b0,
    CLR_SWEEP = 1'b1
  } clr_state_e;

endpackage

// File: rtl/reg_file_clear_seq.sv
// Clear sequencer: walks every register address once
// per request and holds ready low while it runs.
import reg_file_pkg::*;

module reg_file_clear_seq #(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr_req,
  output logic              o_ready,
  output logic              o_clr_active,
  output logic [ADDR_W-1:0] o_clr_addr
);

  clr_state_e        r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              w_last;

  assign w_last = (r_cnt == {ADDR_W{1'b1}});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= CLR_IDLE;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        CLR_IDLE: begin
          if (i_clr_req) begin
            r_state <= CLR_SWEEP;
            r_cnt   <= '0;
          end
        end
        CLR_SWEEP: begin
          // requests during a sweep never restart it
          if (w_last) begin
            r_state <= CLR_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= CLR_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_ready      = (r_state == CLR_IDLE);
  assign o_clr_active = (r_state == CLR_SWEEP);
  assign o_clr_addr   = r_cnt;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with busy scoreboard,
// write-through bypass and a counted clear sweep.
import reg_file_pkg::*;

module reg_file_mp #(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     alloc_en,
  input  logic [ADDR_W-1:0]        alloc_addr,
  input  logic                     clr_req,
  output logic                     ready
);

  localparam int NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [NREGS];
  logic [NREGS-1:0]  r_busy;

  logic              w_ready;
  logic              w_clr_active;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_wr_zero;
  logic              w_al_zero;
  logic              w_wr_acc;
  logic              w_al_acc;

  reg_file_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clr (
    .clk          (clk),
    .rst          (rst),
    .i_clr_req    (clr_req),
    .o_ready      (w_ready),
    .o_clr_active (w_clr_active),
    .o_clr_addr   (w_clr_addr)
  );

  assign ready     = w_ready;
  assign w_wr_zero = (ZERO_REG != 0) && (wr_addr == '0);
  assign w_al_zero = (ZERO_REG != 0) && (alloc_addr == '0);
  assign w_wr_acc  = wr_en && w_ready && !w_wr_zero;
  assign w_al_acc  = alloc_en && w_ready && !w_al_zero;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_mem[i] <= '0;
      end
      r_busy <= '0;
    end else if (w_clr_active) begin
      r_mem[w_clr_addr]  <= '0;
      r_busy[w_clr_addr] <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_mem[wr_addr]  <= wr_data;
        r_busy[wr_addr] <= 1'b0;
      end
      // a same-address alloc overrides the write's busy clear
      if (w_al_acc) begin
        r_busy[alloc_addr] <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] w_a;
    logic [DATA_W-1:0] w_d;
    logic              w_b;
    logic              w_hit;

    assign w_a   = rd_addr[g*ADDR_W +: ADDR_W];
    assign w_hit = (BYPASS != 0) && w_wr_acc
                   && (wr_addr == w_a);

    always_comb begin
      w_d = r_mem[w_a];
      w_b = r_busy[w_a];
      if (w_hit) begin
        w_d = wr_data;
        w_b = w_al_acc && (alloc_addr == w_a);
      end
      if ((ZERO_REG != 0) && (w_a == '0)) begin
        w_d = '0;
        w_b = 1'b0;
      end
    end

    assign rd_data[g*DATA_W +: DATA_W] = w_d;
    assign rd_busy[g]                  = w_b;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: bypass and non-bypass
// instances checked against an array model every cycle.
module tb_reg_file_mp;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int NR = 2;
  localparam int N  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NR*AW-1:0] rd_addr;
  logic [DW-1:0]    wr_data;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    alloc_addr;
  logic             wr_en;
  logic             alloc_en;
  logic             clr_req;

  logic [NR*DW-1:0] rdd_b;
  logic [NR*DW-1:0] rdd_n;
  logic [NR-1:0]    rdb_b;
  logic [NR-1:0]    rdb_n;
  logic             rdy_b;
  logic             rdy_n;

  int n_vec = 0;
  int n_err = 0;
  int lowcnt;

  always #5 clk = ~clk;

  reg_file_mp #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR),
    .ZERO_REG(1), .BYPASS(1)
  ) u_byp (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_data(rdd_b), .rd_busy(rdb_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr),
    .clr_req(clr_req), .ready(rdy_b)
  );

  reg_file_mp #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR),
    .ZERO_REG(1), .BYPASS(0)
  ) u_nob (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_data(rdd_n), .rd_busy(rdb_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr),
    .clr_req(clr_req), .ready(rdy_n)
  );

  // model: m_left counts registers still to be swept
  logic [DW-1:0] m_mem [N];
  logic          m_busy [N];
  int            m_left;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        m_mem[i]  = '0;
        m_busy[i] = 1'b0;
      end
      m_left = 0;
    end else if (m_left > 0) begin
      m_mem[N-m_left]  = '0;
      m_busy[N-m_left] = 1'b0;
      m_left = m_left - 1;
    end else begin
      if (wr_en && wr_addr != 0) begin
        m_mem[wr_addr]  = wr_data;
        m_busy[wr_addr] = 1'b0;
      end
      if (alloc_en && alloc_addr != 0)
        m_busy[alloc_addr] = 1'b1;
      if (clr_req)
        m_left = N;
    end
  end

  function automatic void model_rd(
    input  logic [AW-1:0] a,
    input  bit            byp,
    output logic [DW-1:0] d,
    output logic          b
  );
    bit acc;
    acc = (m_left == 0);
    d = m_mem[a];
    b = m_busy[a];
    if (byp && acc && wr_en && wr_addr != 0 && wr_addr == a) begin
      d = wr_data;
      b = alloc_en && (alloc_addr == a);
    end
    if (a == 0) begin
      d = '0;
      b = 1'b0;
    end
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [DW-1:0] d;
    logic          b;
    for (int p = 0; p < NR; p++) begin
      model_rd(rd_addr[p*AW +: AW], 1'b1, d, b);
      chk($sformatf("cyc_byp_data%0d", p), 32'(rdd_b[p*DW +: DW]), 32'(d));
      chk($sformatf("cyc_byp_busy%0d", p), 32'(rdb_b[p]), 32'(b));
      model_rd(rd_addr[p*AW +: AW], 1'b0, d, b);
      chk($sformatf("cyc_nob_data%0d", p), 32'(rdd_n[p*DW +: DW]), 32'(d));
      chk($sformatf("cyc_nob_busy%0d", p), 32'(rdb_n[p]), 32'(b));
    end
    chk("cyc_ready_b", 32'(rdy_b), 32'(m_left == 0));
    chk("cyc_ready_n", 32'(rdy_n), 32'(m_left == 0));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic setrd(input int a0, input int a1);
    rd_addr = {AW'(a1), AW'(a0)};
  endtask

  task automatic idle_in();
    wr_en    = 1'b0;
    alloc_en = 1'b0;
    clr_req  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_in();
    rd_addr    = '0;
    wr_addr    = '0;
    wr_data    = '0;
    alloc_addr = '0;
    #2 rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;

    for (int a = 0; a < N; a++) begin
      setrd(a, N - 1 - a);
      settle();
      chk("rst_data0", 32'(rdd_b[15:0]), 32'h0);
      chk("rst_data1", 32'(rdd_b[31:16]), 32'h0);
      chk("rst_busy", 32'(rdb_b), 32'h0);
      chk("rst_ready", 32'(rdy_b), 32'h1);
      tick();
    end

    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF;
    setrd(5, 0);
    settle();
    chk("byp_same", 32'(rdd_b[15:0]), 32'hBEEF);
    chk("nob_same", 32'(rdd_n[15:0]), 32'h0);
    tick();
    wr_en = 1'b0;
    settle();
    chk("nob_next", 32'(rdd_n[15:0]), 32'hBEEF);
    tick();

    alloc_en = 1'b1; alloc_addr = 4'd7;
    setrd(7, 5);
    settle();
    chk("alloc_pre", 32'(rdb_b[0]), 32'h0);
    tick();
    alloc_en = 1'b0;
    repeat (3) begin
      settle();
      chk("busy_hold_b", 32'(rdb_b[0]), 32'h1);
      chk("busy_hold_n", 32'(rdb_n[0]), 32'h1);
      tick();
    end
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h1234;
    settle();
    chk("wr_byp_busy", 32'(rdb_b[0]), 32'h0);
    chk("wr_byp_data", 32'(rdd_b[15:0]), 32'h1234);
    chk("wr_nob_busy", 32'(rdb_n[0]), 32'h1);
    tick();
    wr_en = 1'b0;
    settle();
    chk("wr_after_busy", 32'(rdb_n[0]), 32'h0);
    chk("wr_after_data", 32'(rdd_n[15:0]), 32'h1234);
    tick();

    wr_en = 1'b1; alloc_en = 1'b1;
    wr_addr = 4'd7; alloc_addr = 4'd7; wr_data = 16'h1234;
    settle();
    chk("aw_byp_busy", 32'(rdb_b[0]), 32'h1);
    chk("aw_byp_data", 32'(rdd_b[15:0]), 32'h1234);
    tick();
    idle_in();
    settle();
    chk("aw_next_busy", 32'(rdb_n[0]), 32'h1);
    chk("aw_next_data", 32'(rdd_n[15:0]), 32'h1234);
    tick();

    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF;
    setrd(0, 0);
    settle();
    chk("r0_wr_data", 32'(rdd_b[15:0]), 32'h0);
    tick();
    wr_en = 1'b0; alloc_en = 1'b1; alloc_addr = 4'd0;
    settle();
    chk("r0_data_after", 32'(rdd_n[15:0]), 32'h0);
    tick();
    alloc_en = 1'b0;
    settle();
    chk("r0_alloc_busy", 32'(rdb_b[0]), 32'h0);
    tick();

    for (int i = 1; i < N; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i);
      wr_data = DW'(32'hA000 + i * 32'h0101);
      tick();
    end
    wr_en = 1'b0;
    setrd(15, 3);
    settle();
    chk("fill15", 32'(rdd_n[15:0]), 32'hAF0F);
    chk("fill3", 32'(rdd_n[31:16]), 32'hA303);
    tick();

    clr_req = 1'b1; wr_en = 1'b1;
    wr_addr = 4'd2; wr_data = 16'h2222;
    setrd(2, 3);
    settle();
    chk("clr_cycle_ready", 32'(rdy_b), 32'h1);
    tick();
    idle_in();
    settle();
    chk("clr_wr_kept", 32'(rdd_n[15:0]), 32'h2222);
    lowcnt = 0;
    while (rdy_b == 1'b0 && lowcnt < 40) begin
      lowcnt++;
      if (lowcnt == 9) begin
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h3333;
        alloc_en = 1'b1; alloc_addr = 4'd3;
      end else begin
        wr_en = 1'b0; alloc_en = 1'b0;
      end
      tick();
      settle();
    end
    idle_in();
    chk("sweep_len", 32'(lowcnt), 32'd16);
    tick();
    for (int a = 0; a < N; a++) begin
      setrd(a, N - 1 - a);
      settle();
      chk("swept_data0", 32'(rdd_b[15:0]), 32'h0);
      chk("swept_data1", 32'(rdd_n[31:16]), 32'h0);
      chk("swept_busy", 32'(rdb_b), 32'h0);
      tick();
    end

    for (int i = 1; i < N; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i);
      wr_data = DW'(i * 32'h0011);
      tick();
    end
    wr_en = 1'b0;
    alloc_en = 1'b1; alloc_addr = 4'd9;
    tick();
    alloc_en = 1'b0;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (4) tick();
    setrd(10, 9);
    settle();
    chk("pre_rst_r10", 32'(rdd_n[15:0]), 32'h00AA);
    chk("pre_rst_busy9", 32'(rdb_n[1]), 32'h1);
    chk("pre_rst_ready", 32'(rdy_n), 32'h0);
    tick();
    rst = 1'b0;
    settle();
    chk("rst_mid_ready", 32'(rdy_b), 32'h1);
    chk("rst_mid_r10", 32'(rdd_n[15:0]), 32'h0);
    chk("rst_mid_busy9", 32'(rdb_n[1]), 32'h0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      setrd(i % N, N - 1 - (i % N));
      settle();
      chk("post_rst_ready", 32'(rdy_b), 32'h1);
      chk("post_rst_data", 32'(rdd_n), 32'h0);
      tick();
    end

    idle_in();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-read-port register file with a pending-write scoreboard and a hardware clear sequencer. It is the next-generation replacement for the fixed 16×16, two-read-port CPU register file. It sits in the decode stage. Reads are combinational with optional write-through bypass. Per-register busy bits let the hazard unit stall on in-flight results. A single request zeroes the whole file in a counted sweep.

## Interface
Parameters:
- DATA_W, 16, register width in bits
- ADDR_W, 4, address width; NREGS = 2**ADDR_W
- NUM_RD, 2, number of read ports (≥1)
- ZERO_REG, 1, when 1, register 0 reads as 0, ignores writes and is never busy
- BYPASS, 1, when 1, a same-cycle accepted write is forwarded to matching read ports

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-low
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i uses slice [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, packed the same way as rd_addr
- rd_busy  out  NUM_RD  scoreboard bit of the addressed register
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- alloc_en  in  1  mark a register as having a pending write
- alloc_addr  in  ADDR_W  register to mark busy
- clr_req  in  1  start a clear sweep (single-cycle pulse or level)
- ready  out  1  high when writes and allocs are accepted; low during a sweep

## Operation
- Storage: NREGS × DATA_W flops, plus an NREGS-bit busy vector.
- Accepted write: wr_en && ready. It writes mem[wr_addr] and clears busy[wr_addr].
  - With ZERO_REG, a write to address 0 is a no-op.
- Accepted alloc: alloc_en && ready. It sets busy[alloc_addr].
  - With ZERO_REG, address 0 is ignored.
- Alloc and write to the same address in the same cycle: data is written and busy ends **set**. The new allocation wins.
- Read port i, in priority order:
  - ZERO_REG and addr 0: data 0, busy 0.
  - BYPASS and accepted write to the same address: data = wr_data, busy = 0 (busy = 1 if a same-address alloc is accepted the same cycle).
  - Otherwise: data = mem[addr], busy = busy[addr].
- Clear FSM, states IDLE and CLEAR:
  - IDLE → CLEAR on clr_req; the counter loads 0.
  - In CLEAR, each cycle zeroes mem[cnt] and busy[cnt], then increments cnt.
  - When cnt == NREGS-1, that register is cleared and the FSM returns to IDLE.
  - clr_req while in CLEAR is ignored; no restart.
  - ready = (state == IDLE).
  - wr_en and alloc_en are dropped (not queued) while ready is low; the source must hold them.
  - Reads during CLEAR return current storage, so a mix of cleared and uncleared values is legal. Bypass is inactive because no write is accepted.
- A clr_req and a write arriving in the same IDLE cycle: the write is accepted, since ready is still high. The sweep then starts and will later zero that register.

## Timing
- Reset (rst low, async): all mem = 0, busy = 0, state IDLE, cnt = 0, ready = 1. rd_data and rd_busy follow combinationally, so every output reads 0 (ready reads 1).
- Write latency: storage updates at the edge; a non-bypassed read sees the new value in the next cycle. The bypassed read sees it in the same cycle.
- Alloc: rd_busy rises in the cycle after the accepting edge.
- Sweep: ready goes low the cycle after the edge that samples clr_req, and stays low for exactly NREGS cycles. ready is 1 again in cycle NREGS+1 after the sampling edge.
- Reset asserted mid-sweep: the FSM goes to IDLE at once and all state is cleared. No residual sweep continues after rst deasserts.
- Reads are purely combinational from rd_addr, storage, and the write/alloc inputs. There are no read-side flops.

## Structure
- Package reg_file_pkg holds:
  - default DATA_W, ADDR_W and NUM_RD localparams
  - the clear FSM state typedef (CLR_IDLE, CLR_SWEEP)
- Sub-module reg_file_clear_seq holds the FSM, the ADDR_W-bit counter and the ready output. It outputs clr_active and clr_addr to the storage array.
- Read ports are generated with a generate loop over NUM_RD.

## Test plan
- Reset then read all 16 addresses on both ports → rd_data 0, rd_busy 0, ready 1.
- Write 0xBEEF to r5 with rd_addr0 = 5 in the same cycle → rd_data0 = 0xBEEF that cycle (bypass). Set BYPASS = 0 → old value 0 that cycle, then 0xBEEF the next.
- Alloc r7, then 3 idle cycles, then write 0x1234 to r7 → rd_busy = 1 for those cycles, 0 after the write. Alloc and write r7 together → data 0x1234, busy stays 1.
- Write 0xFFFF to r0 → reads 0, busy 0. Alloc r0 → busy stays 0.
- Fill r1–r15, then pulse clr_req → ready low for exactly 16 cycles. A wr_en to r3 mid-sweep is dropped. All registers read 0 after the sweep.
- Assert rst for 1 cycle 5 cycles into a sweep → ready 1 immediately, all registers 0, no further sweep activity.
